pong_match_ctrl: RTL and testbench

Match-level controller for the two-button LED pong game. It owns the 8-LED ball register and a programmable step timer, and it detects hits, misses and early swings. It keeps both 4-bit scores, alternates serve and display phases, speeds the ball up after every return, and ends the match at a target score. It replaces free-running shift logic with a sequenced, tick-gated datapath driven from the system clock.

---
 rtl/pong_match_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: two-button LED pong match controller with tick-gated ball,
// scoring, serve/display phases and match end.
module pong_match_ctrl #(
    parameter int TICK_INIT   = 8,
    parameter int TICK_MIN    = 2,
    parameter int TICK_DEC    = 1,
    parameter int WIN_SCORE   = 7,
    parameter int SHOW_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_r,
    input  logic       sw_l,
    output logic [7:0] led,
    output logic [3:0] score_r,
    output logic [3:0] score_l,
    output logic [2:0] state,
    output logic       match_over,
    output logic       winner
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        MOVE_L = 3'd2,
        MOVE_R = 3'd3,
        POINT  = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam int TW = $clog2(TICK_INIT + 1);
    localparam int SW = $clog2(SHOW_CYCLES + 1);
    localparam logic [TW-1:0] P_INIT = TW'(TICK_INIT);
    localparam logic [TW-1:0] P_MIN  = TW'(TICK_MIN);
    localparam logic [TW-1:0] P_DEC  = TW'(TICK_DEC);
    localparam logic [3:0]    P_WIN  = 4'(WIN_SCORE);
    localparam logic [SW-1:0] P_SHOW = SW'(SHOW_CYCLES - 1);

    state_t        r_state;
    logic [7:0]    r_led;
    logic [3:0]    r_score_r, r_score_l;
    logic          r_match_over, r_winner, r_server;
    logic [TW-1:0] r_period, r_tick;
    logic [SW-1:0] r_show;
    logic          r_sw_r, r_sw_r_q, r_sw_l, r_sw_l_q;

    logic          w_press_r, w_press_l, w_step;
    logic [TW-1:0] w_period_next;
    logic [3:0]    w_score_r_inc, w_score_l_inc;

    // Buttons are sampled once before edge detection, giving two-edge latency.
    assign w_press_r     = r_sw_r & ~r_sw_r_q;
    assign w_press_l     = r_sw_l & ~r_sw_l_q;
    assign w_step        = r_tick == '0;
    assign w_period_next = (r_period - P_MIN >= P_DEC) ? r_period - P_DEC : P_MIN;
    assign w_score_r_inc = r_score_r + 4'd1;
    assign w_score_l_inc = r_score_l + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_led        <= 8'h01;
            r_score_r    <= '0;
            r_score_l    <= '0;
            r_match_over <= 1'b0;
            r_winner     <= 1'b0;
            r_server     <= 1'b0;
            r_period     <= P_INIT;
            r_tick       <= '0;
            r_show       <= '0;
            r_sw_r       <= 1'b0;
            r_sw_r_q     <= 1'b0;
            r_sw_l       <= 1'b0;
            r_sw_l_q     <= 1'b0;
        end else begin
            r_sw_r   <= sw_r;
            r_sw_r_q <= r_sw_r;
            r_sw_l   <= sw_l;
            r_sw_l_q <= r_sw_l;
            case (r_state)
                IDLE: begin
                    if (w_press_r) begin
                        r_state  <= MOVE_L;
                        r_led    <= 8'h01;
                        r_period <= P_INIT;
                        r_tick   <= P_INIT - TW'(1);
                    end else if (w_press_l) begin
                        r_state  <= MOVE_R;
                        r_led    <= 8'h80;
                        r_period <= P_INIT;
                        r_tick   <= P_INIT - TW'(1);
                    end
                end
                SERVE: begin
                    if (!r_server && w_press_r) begin
                        r_state  <= MOVE_L;
                        r_period <= P_INIT;
                        r_tick   <= P_INIT - TW'(1);
                    end else if (r_server && w_press_l) begin
                        r_state  <= MOVE_R;
                        r_period <= P_INIT;
                        r_tick   <= P_INIT - TW'(1);
                    end
                end
                MOVE_L: begin
                    if (w_press_l && r_led == 8'h80) begin
                        r_state  <= MOVE_R;
                        r_period <= w_period_next;
                        r_tick   <= w_period_next - TW'(1);
                    end else if (w_press_l || (w_step && r_led == 8'h80)) begin
                        r_state   <= POINT;
                        r_score_r <= w_score_r_inc;
                        r_led     <= {r_score_l, w_score_r_inc};
                        r_server  <= 1'b0;
                        r_show    <= P_SHOW;
                    end else if (w_step) begin
                        r_led  <= r_led << 1;
                        r_tick <= r_period - TW'(1);
                    end else begin
                        r_tick <= r_tick - TW'(1);
                    end
                end
                MOVE_R: begin
                    if (w_press_r && r_led == 8'h01) begin
                        r_state  <= MOVE_L;
                        r_period <= w_period_next;
                        r_tick   <= w_period_next - TW'(1);
                    end else if (w_press_r || (w_step && r_led == 8'h01)) begin
                        r_state   <= POINT;
                        r_score_l <= w_score_l_inc;
                        r_led     <= {w_score_l_inc, r_score_r};
                        r_server  <= 1'b1;
                        r_show    <= P_SHOW;
                    end else if (w_step) begin
                        r_led  <= r_led >> 1;
                        r_tick <= r_period - TW'(1);
                    end else begin
                        r_tick <= r_tick - TW'(1);
                    end
                end
                POINT: begin
                    if (r_show == '0) begin
                        if (r_score_r == P_WIN || r_score_l == P_WIN) begin
                            r_state      <= OVER;
                            r_match_over <= 1'b1;
                            r_winner     <= r_score_l == P_WIN;
                        end else begin
                            r_state <= SERVE;
                            r_led   <= r_server ? 8'h80 : 8'h01;
                        end
                    end else begin
                        r_show <= r_show - SW'(1);
                    end
                end
                OVER: r_state <= OVER;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign led        = r_led;
    assign score_r    = r_score_r;
    assign score_l    = r_score_l;
    assign state      = r_state;
    assign match_over = r_match_over;
    assign winner     = r_winner;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: randomized players driven against a behavioural match model;
// predicted output changes are queued and checked by an independent monitor.
module tb_pong_match_ctrl;
    localparam int TI = 4, TM = 2, TD = 1, WS = 3, SC = 3;
    localparam int NCYC = 30000;

    logic       clk = 1'b0, rst = 1'b1, sw_r = 1'b0, sw_l = 1'b0;
    logic [7:0] led;
    logic [3:0] score_r, score_l;
    logic [2:0] state;
    logic       match_over, winner;

    pong_match_ctrl #(
        .TICK_INIT(TI), .TICK_MIN(TM), .TICK_DEC(TD), .WIN_SCORE(WS), .SHOW_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst), .sw_r(sw_r), .sw_l(sw_l), .led(led),
        .score_r(score_r), .score_l(score_l), .state(state),
        .match_over(match_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        logic [20:0] t;
    } exp_t;
    exp_t q[$];
    int   checks = 0, failures = 0;
    logic mon_en = 1'b0;

    // Match model: ball as a position 0..7, scores and timers as plain integers.
    int   m_st, m_pos, m_sr, m_sl, m_per, m_tick, m_show, m_srv;
    logic h_r, hq_r, h_l, hq_l;

    function automatic logic [20:0] dut_tuple();
        return {state, led, score_l, score_r, match_over, winner};
    endfunction

    function automatic logic [20:0] model_tuple();
        logic [7:0] l;
        logic [3:0] a, b;
        logic [2:0] s;
        a = m_sl[3:0];
        b = m_sr[3:0];
        s = m_st[2:0];
        l = (m_st == 4 || m_st == 5) ? {a, b} : 8'(1 << m_pos);
        return {s, l, a, b, m_st == 5, m_st == 5 && m_sl == WS};
    endfunction

    task automatic launch(input int from_left);
        m_st   = from_left ? 3 : 2;
        m_pos  = from_left ? 7 : 0;
        m_per  = TI;
        m_tick = TI - 1;
    endtask

    task automatic award(input int scorer);
        if (scorer == 0) m_sr++;
        else m_sl++;
        m_srv  = scorer;
        m_st   = 4;
        m_show = SC - 1;
    endtask

    task automatic move(input logic p, input int end_pos, input int dirn, input int scorer, input int nxt);
        if (p && m_pos == end_pos) begin
            m_st   = nxt;
            m_per  = (m_per - TD > TM) ? m_per - TD : TM;
            m_tick = m_per - 1;
        end else if (p || (m_tick == 0 && m_pos == end_pos)) begin
            award(scorer);
        end else if (m_tick == 0) begin
            m_pos += dirn;
            m_tick = m_per - 1;
        end else begin
            m_tick--;
        end
    endtask

    task automatic model_step(input logic r);
        logic pr, pl;
        pr = h_r & ~hq_r;
        pl = h_l & ~hq_l;
        if (r) begin
            m_st = 0; m_pos = 0; m_sr = 0; m_sl = 0;
            m_per = TI; m_tick = 0; m_show = 0; m_srv = 0;
            return;
        end
        case (m_st)
            0: if (pr) launch(0); else if (pl) launch(1);
            1: if (m_srv == 0 && pr) launch(0); else if (m_srv == 1 && pl) launch(1);
            2: move(pl, 7, 1, 0, 3);
            3: move(pr, 0, -1, 1, 2);
            4: begin
                if (m_show == 0) begin
                    if (m_sr == WS || m_sl == WS) m_st = 5;
                    else begin
                        m_st  = 1;
                        m_pos = m_srv ? 7 : 0;
                    end
                end else m_show--;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: every change of the DUT's visible outputs must match the next prediction.
    initial begin
        logic [20:0] prev, cur;
        exp_t e;
        wait (mon_en);
        prev = dut_tuple();
        forever begin
            @(posedge clk);
            #1;
            cur = dut_tuple();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h expected no change", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if (e.t !== cur || e.stamp != cyc) begin
                        failures++;
                        $display("FAIL scoreboard cyc=%0d got=%h required=%h at cyc=%0d", cyc, cur, e.t, e.stamp);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        logic [20:0] prev_t, t;
        logic        rn, wr, wl, nr, nl;
        int          u, over_cnt, hold_r, hold_l;
        over_cnt = 0; hold_r = 0; hold_l = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {8'd0, state}, 11'd0);
        chk("reset_led", {13'd0, led}, 21'h01);
        chk("reset_score_r", {17'd0, score_r}, 21'd0);
        chk("reset_score_l", {17'd0, score_l}, 21'd0);
        chk("reset_match_over", {20'd0, match_over}, 21'd0);
        chk("reset_winner", {20'd0, winner}, 21'd0);
        h_r = 0; hq_r = 0; h_l = 0; hq_l = 0;
        model_step(1'b1);
        prev_t = model_tuple();
        mon_en = 1'b1;
        for (int n = 0; n < NCYC; n++) begin
            over_cnt = (m_st == 5) ? over_cnt + 1 : 0;
            rn = (n < 2) || over_cnt > 25 || $urandom_range(0, 399) == 0;
            model_step(rn);
            t = model_tuple();
            if (t != prev_t) q.push_back('{cyc + 1, t});
            prev_t = t;
            wr = 0; wl = 0;
            u = $urandom_range(0, 59);
            case (m_st)
                0: begin wr = u < 20 || u >= 40; wl = u < 30; end
                1: begin wr = m_srv == 0 ? u < 12 : u < 4; wl = m_srv == 1 ? u < 12 : u < 4; end
                2: begin wl = m_pos == 7 ? u < 40 : u < 2; wr = u >= 56; end
                3: begin wr = m_pos == 0 ? u < 40 : u < 2; wl = u >= 56; end
                default: begin wr = u < 6; wl = u >= 54; end
            endcase
            if (hold_r == 0 && $urandom_range(0, 499) == 0) hold_r = $urandom_range(20, 80);
            if (hold_l == 0 && $urandom_range(0, 499) == 0) hold_l = $urandom_range(20, 80);
            if (hold_r > 0) begin nr = 1'b1; hold_r--; end else nr = wr & ~sw_r;
            if (hold_l > 0) begin nl = 1'b1; hold_l--; end else nl = wl & ~sw_l;
            if (rn) begin
                h_r = 0; hq_r = 0; h_l = 0; hq_l = 0;
            end else begin
                hq_r = h_r; h_r = nr; hq_l = h_l; h_l = nl;
            end
            rst  = rn;
            sw_r = nr;
            sw_l = nl;
            @(negedge clk);
        end
        chk("queue_drained", 21'(q.size()), 21'd0);
        chk("final_outputs", dut_tuple(), prev_t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
